// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes and bridge FSM states
package axil_pkg;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} axil_resp_t;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} axil_mst_state_t;
endpackage

// File: rtl/axil_timeout_counter.sv
// axil_timeout_counter: saturating response-wait counter; TIMEOUT_CYCLES of 0 never expires
module axil_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt;
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES));
  always_ff @(posedge aclk)
    cnt <= (!aresetn || clear) ? '0 : cnt + CW'(enable && !expired);
endmodule

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: single-outstanding request port to AXI4-Lite master with response timeout
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);
  axil_mst_state_t       state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  aw_done, w_done, aw_hs, w_hs, waiting, expired;
  assign aw_hs          = m_axil_awvalid && m_axil_awready;
  assign w_hs           = m_axil_wvalid && m_axil_wready;
  assign waiting        = (state == WRESP) || (state == RDATA);
  assign m_axil_awaddr  = addr;
  assign m_axil_araddr  = addr;
  assign m_axil_wdata   = wdata;
  assign m_axil_wstrb   = wstrb;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;
  // Outside the two wait states the counter is held clear, so each wait starts from zero
  axil_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= IDLE;
      addr           <= '0;
      wdata          <= '0;
      wstrb          <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= '0;
      fault          <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !fault;
          if (req_valid && req_ready) begin
            req_ready      <= 1'b0;
            addr           <= req_addr;
            wdata          <= req_wdata;
            wstrb          <= req_wstrb;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            state          <= req_write ? WADDR : RADDR;
            m_axil_awvalid <= req_write;
            m_axil_wvalid  <= req_write;
            m_axil_arvalid <= !req_write;
          end
        end
        WADDR: begin
          if (aw_hs) begin
            m_axil_awvalid <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            m_axil_wvalid <= 1'b0;
            w_done        <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state         <= WRESP;
            m_axil_bready <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axil_bvalid || expired) begin
            state         <= RESP;
            m_axil_bready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_resp      <= m_axil_bvalid ? m_axil_bresp : SLVERR;
            fault         <= fault || !m_axil_bvalid;
          end
        end
        RADDR: begin
          if (m_axil_arready) begin
            state          <= RDATA;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (m_axil_rvalid || expired) begin
            state         <= RESP;
            m_axil_rready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= m_axil_rvalid ? m_axil_rdata : '0;
            rsp_resp      <= m_axil_rvalid ? m_axil_rresp : SLVERR;
            fault         <= fault || !m_axil_rvalid;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= !fault;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: directed bench with a delay-programmable AXI-Lite memory slave
module tb_axil_master_bridge;
  import axil_pkg::*;
  logic        aclk, aresetn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, fault;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  int checks = 0, errors = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit r_never = 0, idle_rv = 0;
  int aw_wait, w_wait, ar_wait;
  int aw_hi = 0, w_hi = 0, b_hs = 0, rr_hi = 0, rr_early = 0;
  logic [31:0] mem [0:63];
  logic [31:0] sa, sd, rd_q, cur_a, cur_d;
  logic [3:0]  ss, cur_s;
  logic        have_aw, have_w, rv;

  axil_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .fault(fault),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Slave: each ready rises after its programmed number of waiting cycles
  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign arready = arvalid && (ar_wait >= ar_dly);
  assign bresp   = 2'b00;
  assign rresp   = 2'b00;
  assign rvalid  = rv || idle_rv;
  assign rdata   = rv ? rd_q : 32'hBAD0BAD0;
  assign cur_a   = (awvalid && awready) ? awaddr : sa;
  assign cur_d   = (wvalid && wready) ? wdata : sd;
  assign cur_s   = (wvalid && wready) ? wstrb : ss;

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; bvalid <= 1'b0; rv <= 1'b0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) begin have_aw <= 1'b1; sa <= awaddr; end
      if (wvalid && wready) begin have_w <= 1'b1; sd <= wdata; ss <= wstrb; end
      if (bvalid && bready) bvalid <= 1'b0;
      if ((have_aw || (awvalid && awready)) && (have_w || (wvalid && wready))) begin
        for (int i = 0; i < 4; i++)
          if (cur_s[i]) mem[cur_a[7:2]][8*i +: 8] <= cur_d[8*i +: 8];
        have_aw <= 1'b0; have_w <= 1'b0; bvalid <= 1'b1;
      end
      if (arvalid && arready) begin
        rv   <= !r_never;
        rd_q <= mem[araddr[7:2]];
      end else if (rv && rready) rv <= 1'b0;
    end
  end

  always @(negedge aclk) begin
    if (awvalid) aw_hi <= aw_hi + 1;
    if (wvalid) w_hi <= w_hi + 1;
    if (bvalid && bready) b_hs <= b_hs + 1;
    if (rready) rr_hi <= rr_hi + 1;
    if (rready && arvalid) rr_early <= rr_early + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [31:0] rd, output logic [1:0] rs, output int lat);
    int n;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge aclk); n++; end
    if (!req_ready) begin
      req_valid = 1'b0; rd = '0; rs = 2'b11; lat = -1;
      return;
    end
    @(negedge aclk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 2000) begin @(negedge aclk); n++; end
    rd = rsp_rdata; rs = rsp_resp; lat = rsp_valid ? n : -1;
    if (hold > 0 && rsp_valid) begin
      repeat (hold) @(negedge aclk);
      check("rsp_held", {rsp_valid, rsp_rdata[30:0]}, {1'b1, rd[30:0]});
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0] rs;
    int lat, s0, s1, s2, s3, s4;
    aresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_ctrl", 32'({req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, fault}), 32'h0);
    check("rst_rsp", rsp_rdata | 32'(rsp_resp), 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("ready_after_rst", 32'(req_ready), 32'h1);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, rs, lat);
    check("t1_wr_lat", 32'(lat), 32'd3);
    check("t1_wr_resp", 32'(rs), 32'h0);
    check("t1_wr_rdata", rd, 32'h0);
    check("t1_turnaround", 32'(req_ready), 32'h1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 2, rd, rs, lat);
    check("t1_rd_lat", 32'(lat), 32'd3);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_resp", 32'(rs), 32'h0);

    do_req(1'b1, 32'h14, 32'h11223344, 4'hF, 0, rd, rs, lat);
    do_req(1'b1, 32'h14, 32'h000000AA, 4'h1, 0, rd, rs, lat);
    do_req(1'b0, 32'h14, 32'h0, 4'h0, 0, rd, rs, lat);
    check("t2_strb_data", rd, 32'h112233AA);

    s0 = aw_hi; s1 = w_hi; s2 = b_hs;
    aw_dly = 3;
    do_req(1'b1, 32'h18, 32'h0BADF00D, 4'hF, 0, rd, rs, lat);
    aw_dly = 0;
    check("t3_aw_cycles", 32'(aw_hi - s0), 32'd4);
    check("t3_w_cycles", 32'(w_hi - s1), 32'd1);
    check("t3_b_count", 32'(b_hs - s2), 32'd1);
    check("t3_resp", 32'(rs), 32'h0);
    check("t3_lat", 32'(lat), 32'd6);
    do_req(1'b0, 32'h18, 32'h0, 4'h0, 0, rd, rs, lat);
    check("t3_rd_data", rd, 32'h0BADF00D);

    do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, rs, lat);
    idle_rv = 1'b1; ar_dly = 2;
    repeat (2) @(negedge aclk);
    check("t4_idle_rvalid", 32'({rvalid, rready}), 32'h2);
    s3 = rr_hi; s4 = rr_early;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, rs, lat);
    idle_rv = 1'b0; ar_dly = 0;
    check("t4_rd_data", rd, 32'hCAFEF00D);
    check("t4_rready_early", 32'(rr_early - s4), 32'd0);
    check("t4_rready_cycles", 32'(rr_hi - s3), 32'd1);
    check("t4_lat", 32'(lat), 32'd5);

    r_never = 1'b1;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, rs, lat);
    check("t5_resp", 32'(rs), 32'(SLVERR));
    check("t5_rdata", rd, 32'h0);
    check("t5_lat", 32'(lat), 32'd19);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    repeat (5) @(negedge aclk);
    check("t5_blocked", 32'({fault, req_ready, arvalid}), 32'h4);
    req_valid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1; r_never = 1'b0;
    repeat (2) @(negedge aclk);
    check("t5_after_rst", 32'({fault, req_ready}), 32'h1);

    aw_dly = 5;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_wstrb = 4'hF;
    @(negedge aclk);
    req_valid = 1'b0;
    check("t6_waddr", 32'({awvalid, wvalid}), 32'h3);
    aresetn = 1'b0;
    @(negedge aclk);
    check("t6_rst_valids", 32'({awvalid, wvalid, fault}), 32'h0);
    check("t6_rst_state", 32'(dut.state), 32'(IDLE));
    aresetn = 1'b1; aw_dly = 0;
    @(negedge aclk);
    do_req(1'b1, 32'h30, 32'h55AA55AA, 4'hF, 0, rd, rs, lat);
    check("t6_wr_lat", 32'(lat), 32'd3);
    check("t6_wr_resp", 32'(rs), 32'h0);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, rs, lat);
    check("t6_rd_data", rd, 32'h55AA55AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
